// File: rtl/clk_div_monitor_if.sv
// Purpose : bundles the divided-clock input and the monitor's result signals.
// Ports   : div_clk    - divided clock level being monitored
//           rise_stb   - one-cycle pulse per div_clk rising edge
//           fall_stb   - one-cycle pulse per div_clk falling edge
//           locked     - divider judged stable
//           err_stb    - half-period out of tolerance
//           lost_stb   - divider stalled
//           last_half  - most recent measured half-period (CNT_W bits)
//           err_count  - saturating error/loss event count
// Modports: master drives div_clk and observes results; slave is the monitor.
interface clk_div_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             div_clk;
  logic             rise_stb;
  logic             fall_stb;
  logic             locked;
  logic             err_stb;
  logic             lost_stb;
  logic [CNT_W-1:0] last_half;
  logic [7:0]       err_count;

  modport master (
    output div_clk,
    input  rise_stb, fall_stb, locked, err_stb, lost_stb, last_half, err_count
  );

  modport slave (
    input  div_clk,
    output rise_stb, fall_stb, locked, err_stb, lost_stb, last_half, err_count
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Purpose : samples a divided clock in the clk_in domain, emits edge strobes,
//           measures each half-period and tracks divider lock/loss.
// Ports   : clk_in - system clock
//           reset  - synchronous active-high reset
//           mon    - clk_div_monitor_if slave (div_clk in, strobes/status out)
module clk_div_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXP_HALF    = 2,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_N      = 4,
  parameter int unsigned LOSS_MAX    = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  clk_div_monitor_if.slave  mon
);

  localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e                 state_q,     state_d;
  logic [SYNC_STAGES-1:0] sync_q,      sync_d;
  logic                   prev_q,      prev_d;
  logic [CNT_W-1:0]       hp_cnt_q,    hp_cnt_d;
  logic [GOOD_W-1:0]      good_cnt_q,  good_cnt_d;
  logic                   rise_stb_q,  rise_stb_d;
  logic                   fall_stb_q,  fall_stb_d;
  logic                   locked_q,    locked_d;
  logic                   err_stb_q,   err_stb_d;
  logic                   lost_stb_q,  lost_stb_d;
  logic [CNT_W-1:0]       last_half_q, last_half_d;
  logic [7:0]             err_count_q, err_count_d;

  logic                   sync_last_c;
  logic                   div_edge_c;
  logic                   good_c;
  logic                   loss_c;
  logic [31:0]            hp_ext_c;

  // Next-state, measurement and output decode
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], mon.div_clk};
    sync_last_c = sync_q[SYNC_STAGES-1];
    prev_d      = sync_last_c;
    div_edge_c  = sync_last_c ^ prev_q;
    hp_ext_c    = 32'(hp_cnt_q);
    // Lower bound written as hp+TOL >= EXP_HALF so it clamps at 0 without underflow
    good_c      = ((hp_ext_c + TOL) >= EXP_HALF) && (hp_ext_c <= (EXP_HALF + TOL));
    loss_c      = !div_edge_c && (hp_ext_c == LOSS_MAX);

    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    last_half_d = last_half_q;
    err_stb_d   = 1'b0;
    lost_stb_d  = 1'b0;
    rise_stb_d  = div_edge_c & sync_last_c;
    fall_stb_d  = div_edge_c & ~sync_last_c;

    if (div_edge_c)             hp_cnt_d = CNT_W'(1);
    else if (hp_cnt_q == CNT_MAX) hp_cnt_d = hp_cnt_q;
    else                        hp_cnt_d = hp_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        // First edge only re-establishes phase; nothing to measure against yet
        if (div_edge_c) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ACQUIRE: begin
        if (div_edge_c) begin
          last_half_d = hp_cnt_q;
          if (good_c) begin
            if ((32'(good_cnt_q) + 32'd1) == LOCK_N) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else begin
            err_stb_d  = 1'b1;
            good_cnt_d = '0;
          end
        end else if (loss_c) begin
          lost_stb_d = 1'b1;
          state_d    = IDLE;
          good_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (div_edge_c) begin
          last_half_d = hp_cnt_q;
          if (!good_c) begin
            err_stb_d  = 1'b1;
            state_d    = ACQUIRE;
            good_cnt_d = '0;
          end
        end else if (loss_c) begin
          lost_stb_d = 1'b1;
          state_d    = IDLE;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        good_cnt_d = '0;
      end
    endcase

    locked_d = (state_d == LOCKED);

    if ((err_stb_d || lost_stb_d) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
    else
      err_count_d = err_count_q;
  end

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      hp_cnt_q    <= '0;
      good_cnt_q  <= '0;
      rise_stb_q  <= 1'b0;
      fall_stb_q  <= 1'b0;
      locked_q    <= 1'b0;
      err_stb_q   <= 1'b0;
      lost_stb_q  <= 1'b0;
      last_half_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      hp_cnt_q    <= hp_cnt_d;
      good_cnt_q  <= good_cnt_d;
      rise_stb_q  <= rise_stb_d;
      fall_stb_q  <= fall_stb_d;
      locked_q    <= locked_d;
      err_stb_q   <= err_stb_d;
      lost_stb_q  <= lost_stb_d;
      last_half_q <= last_half_d;
      err_count_q <= err_count_d;
    end
  end

  assign mon.rise_stb  = rise_stb_q;
  assign mon.fall_stb  = fall_stb_q;
  assign mon.locked    = locked_q;
  assign mon.err_stb   = err_stb_q;
  assign mon.lost_stb  = lost_stb_q;
  assign mon.last_half = last_half_q;
  assign mon.err_count = err_count_q;

endmodule
